// File: rtl/signmag_complement_conv.sv
// Bit-serial converter between sign-magnitude, ones' complement and two's complement.
// Latency: start accepted at edge 0, done high the cycle after edge WIDTH (bypass: after edge 0).
// Backpressure: none; start is only sampled in IDLE/DONE, and start while busy is dropped.
//
// Ports:
//   clk, rst          posedge clock, synchronous active-high reset (aborts any operation)
//   start, mode, din  request, conversion mode (00 SM->1C, 01 SM->2C, 10 2C->SM, 11 1C->SM), operand
//   busy              high while shifting magnitude bits and packing the result
//   done              one-cycle pulse; dout/neg_zero/ovf valid and held until the next result
//   dout              converted word
//   neg_zero          negative-zero operand seen (SM 100..0 or 1C 11..1)
//   ovf               2C->SM of 100..0, which has no SM encoding
// Optional build macro SIGNMAG_CONV_BYPASS_EN: positive operands skip the serial path.
module signmag_complement_conv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             neg_zero,
    output logic             ovf
);

    localparam int MW = WIDTH - 1;
    localparam int IW = (MW > 1) ? $clog2(MW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PACK, DONE} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   din_q;
    logic [IW-1:0]      bit_idx;
    logic               carry;
    logic [MW-1:0]      res;

    logic [MW-1:0]      mag;
    logic               inv_bit;
    logic               out_bit;
    logic [WIDTH-1:0]   pack_dout;
    logic               pack_nz;
    logic               pack_ovf;

    assign mag     = din_q[MW-1:0];
    assign inv_bit = ~mag[bit_idx];
    assign out_bit = inv_bit ^ carry;

    // Result selection at PACK. The serial path yields the plain complement;
    // the two zero-magnitude corner cases that have no natural encoding are patched here.
    always_comb begin
        pack_dout = {1'b1, res};
        pack_nz   = 1'b0;
        pack_ovf  = 1'b0;
        if (!din_q[MW]) begin
            pack_dout = din_q;
        end else begin
            case (mode_q)
                2'b00: pack_nz = (mag == '0);
                2'b01: begin
                    pack_nz = (mag == '0);
                    if (mag == '0) pack_dout = '0;
                end
                2'b10: begin
                    pack_ovf = (mag == '0);
                    if (mag == '0) pack_dout = '1;
                end
                default: pack_nz = &mag;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            din_q    <= '0;
            bit_idx  <= '0;
            carry    <= 1'b0;
            res      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            neg_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        din_q   <= din;
                        bit_idx <= '0;
                        // +1 needed only for the two's-complement directions (01, 10)
                        carry   <= mode[1] ^ mode[0];
`ifdef SIGNMAG_CONV_BYPASS_EN
                        if (!din[WIDTH-1]) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            dout     <= din;
                            neg_zero <= 1'b0;
                            ovf      <= 1'b0;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
`else
                        state <= SHIFT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // LSB first: each result bit enters at the top and walks down
                    res   <= {out_bit, res[MW-1:1]};
                    carry <= inv_bit & carry;
                    if (bit_idx == IW'(MW - 1)) begin
                        state <= PACK;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                PACK: begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    dout     <= pack_dout;
                    neg_zero <= pack_nz;
                    ovf      <= pack_ovf;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
